uart_icb_master: RTL and testbench
==================================

UART_ICB_MASTER -- requirements
Module: uart_icb_master

Interface
REQ-001 SHALL have parameter PA_SIZE, default 32: width of the ICB address.
REQ-002 SHALL have parameter DATA_ADDR, default 32'h1001_3000: UART data register address.
REQ-003 SHALL have parameter CSR_ADDR, default 32'h1001_3004: UART CSR address; rdata bit0 = tx_ok.
REQ-004 SHALL have parameter CTRL_ADDR, default 32'h1001_3008: UART ctrl register address.
REQ-005 SHALL have parameter CSR_CFG, default 32'h0000_0100: CSR value written at init (baudrate 2'b01 = 9600 bps, divisor 0).
REQ-006 SHALL have parameter CTRL_CFG, default 32'h0000_1011: ctrl value written at init (baud_en, tx_en, n_parity).
REQ-007 SHALL have parameter BUSY_TMO, default 255: maximum number of busy-phase polls.
REQ-008 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-009 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port in_valid  input  1  byte push request.
REQ-011 SHALL have port in_ready  output  1  FIFO not full.
REQ-012 SHALL have port in_data  input  8  byte to transmit.
REQ-013 SHALL have ICB initiator command ports: o_icb_cmd_valid out 1; o_icb_cmd_ready in 1; o_icb_cmd_addr out PA_SIZE; o_icb_cmd_read out 1; o_icb_cmd_wdata out 32.
REQ-014 SHALL have ICB initiator response ports: o_icb_rsp_valid in 1; o_icb_rsp_ready out 1; o_icb_rsp_rdata in 32.
REQ-015 SHALL have status outputs: cfg_done out 1, set once init is complete; busy out 1, high in any state other than IDLE; tx_count out 16, count of data writes.

Function
REQ-016 SHALL buffer input bytes in a 4-entry FIFO; push when in_valid && in_ready; in_ready = count != 4; wrap-around pointers.
REQ-017 SHALL run this FSM: CFG_CSR -> CFG_CTRL -> IDLE -> POLL_IDLE -> WR_DATA -> POLL_BUSY -> IDLE.
REQ-018 CFG_CSR SHALL write CSR_CFG to CSR_ADDR; CFG_CTRL SHALL write CTRL_CFG to CTRL_ADDR; after the CFG_CTRL response, cfg_done=1, held until reset.
REQ-019 IDLE SHALL go to POLL_IDLE when the FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-020 POLL_IDLE SHALL read CSR_ADDR; on rdata[0]=1 go to WR_DATA, else reissue the read.
REQ-021 WR_DATA SHALL write {24'h0, FIFO head} to DATA_ADDR; it SHALL pop the FIFO and increment tx_count (mod 2^16) on the response handshake.
REQ-022 POLL_BUSY SHALL read CSR_ADDR until rdata[0]=0 or BUSY_TMO polls have completed, then go to IDLE; this absorbs the tx_ok fall latency.
REQ-023 Each access SHALL have two phases: CMD (cmd_valid=1) until the cmd_valid && cmd_ready cycle, then RSP until rsp_valid && rsp_ready.
REQ-024 At most one transaction SHALL be outstanding; the next cmd_valid SHALL rise no earlier than the cycle after the response handshake.
REQ-025 addr/read/wdata SHALL be stable while cmd_valid=1 and not ready; cmd_valid SHALL NOT drop before ready.
REQ-026 o_icb_rsp_ready SHALL be 1 exactly in the RSP phase; rdata SHALL be sampled only on the response handshake.
REQ-027 In write transactions, o_icb_cmd_read SHALL be 0; in reads, o_icb_cmd_wdata SHALL be 0.
REQ-028 A simultaneous push and pop SHALL leave the FIFO count unchanged; a push when full SHALL be ignored.
REQ-029 The busy-poll counter SHALL be 8-bit, cleared on entry to POLL_BUSY, and saturate at BUSY_TMO.

Reset
REQ-030 On rst_n=0, at once: FSM=CFG_CSR, CMD phase; FIFO empty; cmd_valid=0; rsp_ready=0; addr/wdata/read=0; cfg_done=0; busy=1; tx_count=0; in_ready=1.
REQ-031 Reset mid-transaction SHALL abandon it with no completion or pop; after release, init SHALL restart with CSR_CFG.
REQ-032 The first cmd_valid SHALL assert on the first clk edge after rst_n rises.

Verification
REQ-033 Reset release, responder always ready -> writes 0x100 to 0x10013004, then 0x1011 to 0x10013008; cfg_done=1.
REQ-034 Push 0x41 with CSR reads returning 1, then 0 -> one read, write 0x41 to 0x10013000, one busy read, IDLE; tx_count=1.
REQ-035 Responder holds cmd_ready=0 for 5 cycles -> addr/wdata/read stable; valid held; no second command issued.
REQ-036 Push 6 bytes back-to-back -> in_ready low after 4 buffered; all 6 written in order; tx_count=6.
REQ-037 CSR rdata[0] stuck at 1 after a data write -> exactly 255 busy polls, then next byte proceeds.
REQ-038 rst_n low during WR_DATA RSP phase -> outputs at reset values at once; restart at CSR_CFG write; tx_count=0.

Source files
------------

// File: rtl/uart_icb_master.sv
// UART transmit front-end: queues bytes in a 4-entry FIFO and feeds them to a
// UART peripheral through an ICB initiator port, after a two-write init.
module uart_icb_master #(
    parameter int unsigned PA_SIZE   = 32,
    parameter logic [31:0] DATA_ADDR = 32'h1001_3000,
    parameter logic [31:0] CSR_ADDR  = 32'h1001_3004,
    parameter logic [31:0] CTRL_ADDR = 32'h1001_3008,
    parameter logic [31:0] CSR_CFG   = 32'h0000_0100,
    parameter logic [31:0] CTRL_CFG  = 32'h0000_1011,
    parameter int unsigned BUSY_TMO  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               o_icb_cmd_valid,
    input  logic               o_icb_cmd_ready,
    output logic [PA_SIZE-1:0] o_icb_cmd_addr,
    output logic               o_icb_cmd_read,
    output logic [31:0]        o_icb_cmd_wdata,
    input  logic               o_icb_rsp_valid,
    output logic               o_icb_rsp_ready,
    input  logic [31:0]        o_icb_rsp_rdata,
    output logic               cfg_done,
    output logic               busy,
    output logic [15:0]        tx_count
);

    typedef enum logic [2:0] {
        ST_CFG_CSR   = 3'd0,
        ST_CFG_CTRL  = 3'd1,
        ST_IDLE      = 3'd2,
        ST_POLL_IDLE = 3'd3,
        ST_WR_DATA   = 3'd4,
        ST_POLL_BUSY = 3'd5
    } state_e;

    typedef enum logic {
        PH_CMD = 1'b0,
        PH_RSP = 1'b1
    } phase_e;

    localparam logic [8:0] BUSY_TMO_W = 9'(BUSY_TMO);
    localparam logic [7:0] BUSY_SAT   = 8'(BUSY_TMO);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [PA_SIZE-1:0] addr_q, addr_d;
    logic               read_q, read_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rsp_ready_q, rsp_ready_d;
    logic               cfg_done_q, cfg_done_d;
    logic               busy_q;
    logic [15:0]        tx_count_q, tx_count_d;
    logic [7:0]         poll_cnt_q, poll_cnt_d;
    logic [8:0]         poll_inc_s;

    logic [PA_SIZE-1:0] acc_addr_s;
    logic               acc_read_s;
    logic [31:0]        acc_wdata_s;

    logic [7:0]         fifo_mem_q [4];
    logic [1:0]         wr_ptr_q, rd_ptr_q;
    logic [2:0]         fifo_cnt_q, fifo_cnt_d;
    logic               in_ready_q;
    logic               push_s, pop_s, rsp_hs_s;

    assign push_s     = in_valid && in_ready_q;
    assign rsp_hs_s   = o_icb_rsp_valid && rsp_ready_q;
    assign poll_inc_s = {1'b0, poll_cnt_q} + 9'd1;

    // Address / direction / write data of the access owned by the current state
    always_comb begin
        acc_addr_s  = {PA_SIZE{1'b0}};
        acc_read_s  = 1'b0;
        acc_wdata_s = 32'h0000_0000;
        case (state_q)
            ST_CFG_CSR: begin
                acc_addr_s  = PA_SIZE'(CSR_ADDR);
                acc_wdata_s = CSR_CFG;
            end
            ST_CFG_CTRL: begin
                acc_addr_s  = PA_SIZE'(CTRL_ADDR);
                acc_wdata_s = CTRL_CFG;
            end
            ST_POLL_IDLE, ST_POLL_BUSY: begin
                acc_addr_s = PA_SIZE'(CSR_ADDR);
                acc_read_s = 1'b1;
            end
            ST_WR_DATA: begin
                acc_addr_s  = PA_SIZE'(DATA_ADDR);
                acc_wdata_s = {24'h00_0000, fifo_mem_q[rd_ptr_q]};
            end
            default: begin
                acc_addr_s  = {PA_SIZE{1'b0}};
                acc_read_s  = 1'b0;
                acc_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer: CMD phase launches then holds the command, RSP phase waits for the reply
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cmd_valid_d = cmd_valid_q;
        addr_d      = addr_q;
        read_d      = read_q;
        wdata_d     = wdata_q;
        rsp_ready_d = rsp_ready_q;
        cfg_done_d  = cfg_done_q;
        tx_count_d  = tx_count_q;
        poll_cnt_d  = poll_cnt_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_cnt_q != 3'd0) begin
                    state_d = ST_POLL_IDLE;
                    phase_d = PH_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG_CSR, ST_CFG_CTRL, ST_POLL_IDLE, ST_WR_DATA, ST_POLL_BUSY: begin
                if (phase_q == PH_CMD) begin
                    if (!cmd_valid_q) begin
                        cmd_valid_d = 1'b1;
                        addr_d      = acc_addr_s;
                        read_d      = acc_read_s;
                        wdata_d     = acc_wdata_s;
                    end else if (o_icb_cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        addr_d      = {PA_SIZE{1'b0}};
                        read_d      = 1'b0;
                        wdata_d     = 32'h0000_0000;
                        rsp_ready_d = 1'b1;
                        phase_d     = PH_RSP;
                    end else begin
                        cmd_valid_d = 1'b1;
                    end
                end else if (rsp_hs_s) begin
                    rsp_ready_d = 1'b0;
                    phase_d     = PH_CMD;
                    case (state_q)
                        ST_CFG_CSR: state_d = ST_CFG_CTRL;
                        ST_CFG_CTRL: begin
                            state_d    = ST_IDLE;
                            cfg_done_d = 1'b1;
                        end
                        ST_POLL_IDLE: begin
                            if (o_icb_rsp_rdata[0]) begin
                                state_d = ST_WR_DATA;
                            end else begin
                                state_d = ST_POLL_IDLE;
                            end
                        end
                        ST_WR_DATA: begin
                            pop_s      = 1'b1;
                            tx_count_d = tx_count_q + 16'd1;
                            poll_cnt_d = 8'd0;
                            state_d    = ST_POLL_BUSY;
                        end
                        ST_POLL_BUSY: begin
                            // tx_ok may lag the data write; give up after BUSY_TMO polls
                            if (!o_icb_rsp_rdata[0]) begin
                                state_d = ST_IDLE;
                            end else if (poll_inc_s >= BUSY_TMO_W) begin
                                poll_cnt_d = BUSY_SAT;
                                state_d    = ST_IDLE;
                            end else begin
                                poll_cnt_d = poll_inc_s[7:0];
                                state_d    = ST_POLL_BUSY;
                            end
                        end
                        default: state_d = ST_CFG_CSR;
                    endcase
                end else begin
                    rsp_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_CFG_CSR;
                phase_d     = PH_CMD;
                cmd_valid_d = 1'b0;
                addr_d      = {PA_SIZE{1'b0}};
                read_d      = 1'b0;
                wdata_d     = 32'h0000_0000;
                rsp_ready_d = 1'b0;
            end
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Sequencer and bus output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CFG_CSR;
            phase_q     <= PH_CMD;
            cmd_valid_q <= 1'b0;
            addr_q      <= {PA_SIZE{1'b0}};
            read_q      <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            rsp_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            busy_q      <= 1'b1;
            tx_count_q  <= 16'd0;
            poll_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmd_valid_q <= cmd_valid_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            wdata_q     <= wdata_d;
            rsp_ready_q <= rsp_ready_d;
            cfg_done_q  <= cfg_done_d;
            busy_q      <= (state_d != ST_IDLE);
            tx_count_q  <= tx_count_d;
            poll_cnt_q  <= poll_cnt_d;
        end
    end

    // Byte FIFO storage and wrap-around pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fifo_cnt_q <= fifo_cnt_d;
            in_ready_q <= (fifo_cnt_d != 3'd4);
        end
    end

    assign in_ready        = in_ready_q;
    assign o_icb_cmd_valid = cmd_valid_q;
    assign o_icb_cmd_addr  = addr_q;
    assign o_icb_cmd_read  = read_q;
    assign o_icb_cmd_wdata = wdata_q;
    assign o_icb_rsp_ready = rsp_ready_q;
    assign cfg_done        = cfg_done_q;
    assign busy            = busy_q;
    assign tx_count        = tx_count_q;

endmodule

// File: tb/tb_uart_icb_master.sv
// Scoreboard bench for uart_icb_master: a randomized ICB responder plays the
// UART peripheral, and the expected command stream is derived per pushed byte.
module tb_uart_icb_master;

    localparam logic [31:0] DATA_A = 32'h1001_3000;
    localparam logic [31:0] CSR_A  = 32'h1001_3004;
    localparam logic [31:0] CTRL_A = 32'h1001_3008;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_rdata = 32'h0;
    logic        cfg_done;
    logic        busy;
    logic [15:0] tx_count;

    cmd_t exp_q[$];
    logic rd_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_tx = 0;
    int   busy_reads = 0;
    int   stall_force = 0;
    bit   wr_delay_force = 1'b0;
    bit   pending = 1'b0;
    bit   pend_rd = 1'b0;
    bit   pend_data = 1'b0;
    int   rsp_delay = 0;
    int   stall_left = 0;
    bit   in_cmd = 1'b0;
    cmd_t held;

    uart_icb_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .o_icb_cmd_valid (cmd_valid),
        .o_icb_cmd_ready (cmd_ready),
        .o_icb_cmd_addr  (cmd_addr),
        .o_icb_cmd_read  (cmd_read),
        .o_icb_cmd_wdata (cmd_wdata),
        .o_icb_rsp_valid (rsp_valid),
        .o_icb_rsp_ready (rsp_ready),
        .o_icb_rsp_rdata (rsp_rdata),
        .cfg_done        (cfg_done),
        .busy            (busy),
        .tx_count        (tx_count)
    );

    always #5 clk = ~clk;

    function automatic cmd_t mk(input logic [31:0] a, input logic r, input logic [31:0] w);
        cmd_t c;
        c.addr  = a;
        c.rd    = r;
        c.wdata = w;
        return c;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: one byte = idle polls until tx_ok, data write, busy polls until
    // tx_ok falls or 255 polls have been made.
    task automatic add_expect(input logic [7:0] b, input int k, input int m);
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(mk(CSR_A, 1'b1, 32'h0));
            rd_q.push_back(1'b0);
        end
        exp_q.push_back(mk(CSR_A, 1'b1, 32'h0));
        rd_q.push_back(1'b1);
        exp_q.push_back(mk(DATA_A, 1'b0, {24'h0, b}));
        if (m >= 255) begin
            for (int i = 0; i < 255; i++) begin
                exp_q.push_back(mk(CSR_A, 1'b1, 32'h0));
                rd_q.push_back(1'b1);
            end
        end else begin
            for (int i = 0; i < m; i++) begin
                exp_q.push_back(mk(CSR_A, 1'b1, 32'h0));
                rd_q.push_back(1'b1);
            end
            exp_q.push_back(mk(CSR_A, 1'b1, 32'h0));
            rd_q.push_back(1'b0);
        end
        exp_tx++;
    endtask

    task automatic send(input int n, input int kmax, input int mmax, input int m_fixed, input bit chk_full);
        int   sent = 0;
        int   cyc = 0;
        bit   low_seen = 1'b0;
        logic rdy;
        logic [7:0] b;
        int   k;
        int   m;
        b = 8'($urandom);
        while (sent < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            in_data  = b;
            rdy      = in_ready;
            if (!rdy && !low_seen && chk_full) begin
                low_seen = 1'b1;
                chk("in_ready_low_after", sent, 4);
            end
            @(posedge clk);
            if (rdy) begin
                k = $urandom_range(0, kmax);
                m = (m_fixed >= 0) ? m_fixed : $urandom_range(0, mmax);
                add_expect(b, k, m);
                sent++;
                b = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("send_all_accepted", sent, n);
        if (chk_full) chk("in_ready_went_low", low_seen, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(exp_q.size() == 0 && !pending && busy == 1'b0) && cyc < 5000);
        chk({tag, "_reached_idle"}, (cyc < 5000), 1'b1);
        chk({tag, "_tx_count"}, tx_count, 16'(exp_tx));
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    // Responder and monitor: decides ready/valid mid-cycle, scoring each handshake
    initial begin : responder
        bit   was_pending;
        bit   rbit;
        cmd_t cur;
        cmd_t e;
        logic [31:0] rnd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending    = 1'b0;
                in_cmd     = 1'b0;
                stall_left = 0;
                cmd_ready  = 1'b0;
                rsp_valid  = 1'b0;
            end else begin
                was_pending = pending;
                cur = mk(cmd_addr, cmd_read, cmd_wdata);
                chk("rsp_ready_phase", rsp_ready, was_pending);
                cmd_ready = 1'b0;
                if (cmd_valid) begin
                    if (!in_cmd) begin
                        in_cmd = 1'b1;
                        held   = cur;
                        stall_left = (stall_force > 0) ? stall_force : $urandom_range(0, 2);
                        stall_force = 0;
                        chk("one_outstanding", was_pending, 1'b0);
                    end else begin
                        chk("cmd_stable", cur, held);
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        cmd_ready = 1'b1;
                        in_cmd    = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_cmd", cur, 96'h0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("cmd", cur, e);
                        end
                        pending   = 1'b1;
                        pend_rd   = cmd_read;
                        pend_data = !cmd_read && (cmd_addr == DATA_A);
                        rsp_delay = (wr_delay_force && pend_data) ? 40 : $urandom_range(0, 2);
                        if (pend_data) busy_reads = 0;
                        else if (cmd_read) busy_reads++;
                    end
                end else if (in_cmd) begin
                    chk("valid_dropped", 1'b0, 1'b1);
                    in_cmd = 1'b0;
                end
                rsp_valid = 1'b0;
                rnd = $urandom;
                rsp_rdata = rnd;
                if (was_pending) begin
                    if (rsp_delay > 0) begin
                        rsp_delay--;
                    end else begin
                        rsp_valid = 1'b1;
                        if (pend_rd) begin
                            rbit = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
                            rnd[0] = rbit;
                            rsp_rdata = rnd;
                        end
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        failures++;
        $display("FAIL watchdog expired checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_rsp_ready", rsp_ready, 1'b0);
        chk("rst_addr", cmd_addr, 32'h0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_cfg_done", cfg_done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_tx_count", tx_count, 16'h0);

        exp_q.push_back(mk(CSR_A, 1'b0, 32'h0000_0100));
        exp_q.push_back(mk(CTRL_A, 1'b0, 32'h0000_1011));
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cmd_valid", cmd_valid, 1'b1);
        wait_idle("init");
        chk("init_cfg_done", cfg_done, 1'b1);

        // single byte, tx_ok 1 then 0
        add_expect_single: begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h41;
            @(posedge clk);
            add_expect(8'h41, 0, 0);
            @(negedge clk);
            in_valid = 1'b0;
            wait_idle("byte41");
        end

        stall_force = 5;
        send(1, 0, 0, 0, 1'b0);
        wait_idle("stall");

        send(6, 2, 2, -1, 1'b1);
        wait_idle("six");

        send(1, 0, 0, 255, 1'b0);
        wait_idle("stuck");
        chk("stuck_busy_polls", busy_reads, 255);
        send(1, 1, 0, 0, 1'b0);
        wait_idle("after_stuck");

        for (int r = 0; r < 4; r++) begin
            send($urandom_range(1, 4), 2, 3, -1, 1'b0);
            wait_idle("random");
        end

        wr_delay_force = 1'b1;
        send(1, 0, 0, 0, 1'b0);
        cyc = 0;
        while (!(pending && pend_data) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_wr_rsp", (cyc < 500), 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_valid", cmd_valid, 1'b0);
        chk("mid_rst_rsp_ready", rsp_ready, 1'b0);
        chk("mid_rst_wdata", cmd_wdata, 32'h0);
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_cfg_done", cfg_done, 1'b0);
        chk("mid_rst_tx_count", tx_count, 16'h0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rd_q.delete();
        exp_tx = 0;
        wr_delay_force = 1'b0;
        exp_q.push_back(mk(CSR_A, 1'b0, 32'h0000_0100));
        exp_q.push_back(mk(CTRL_A, 1'b0, 32'h0000_1011));
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_cmd_valid", cmd_valid, 1'b1);
        wait_idle("restart");
        chk("restart_cfg_done", cfg_done, 1'b1);
        send(2, 1, 1, -1, 1'b0);
        wait_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
